// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
// The struct widths below must match the top-level width parameters.
package axi4_lite_pkg;

    localparam int unsigned c_addr_width = 28;
    localparam int unsigned c_data_width = 64;
    localparam int unsigned c_strb_width = c_data_width / 8;

    // AXI response codes (BRESP / RRESP)
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RESP
    } state_e;

    // One captured command beat
    typedef struct packed {
        logic                    we;
        logic [c_addr_width-1:0] addr;
        logic [c_data_width-1:0] data;
        logic [c_strb_width-1:0] strb;
    } cmd_t;

    // One completion returned to the requester
    typedef struct packed {
        logic                    we;
        logic [c_data_width-1:0] data;
        logic [1:0]              code;
    } resp_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used as the transaction watchdog. o_reach pulses
// in the enabled cycle whose increment lands exactly on the terminal value.
module sat_counter #(
    parameter int unsigned       width_p    = 11,
    parameter logic [width_p-1:0] terminal_p = '1
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic i_clear,
    input  logic i_en,
    output logic o_reach
);

    logic [width_p-1:0] r_count;

    // Count enabled cycles, holding at the terminal value instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != terminal_p)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_reach = i_en & ~i_clear & (r_count == (terminal_p - 1'b1));

endmodule

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one AXI
// read or write out, one completion back on a valid/ready response stream.
// Every output is driven straight from a register.
module axi4_lite_cmd_master
    import axi4_lite_pkg::*;
#(
    parameter int unsigned addr_width_p     = c_addr_width,
    parameter int unsigned data_width_p     = c_data_width,
    parameter int unsigned timeout_cycles_p = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    // command stream
    input  logic                      cmd_v_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [addr_width_p-1:0]   cmd_addr_i,
    input  logic [data_width_p-1:0]   cmd_data_i,
    input  logic [data_width_p/8-1:0] cmd_strb_i,
    // response stream
    output logic                      resp_v_o,
    input  logic                      resp_ready_i,
    output logic                      resp_we_o,
    output logic [data_width_p-1:0]   resp_data_o,
    output logic [1:0]                resp_code_o,
    output logic                      timeout_o,
    // AW channel
    output logic [addr_width_p-1:0]   awaddr_o,
    output logic [2:0]                awprot_o,
    output logic                      awvalid_o,
    input  logic                      awready_i,
    // W channel
    output logic [data_width_p-1:0]   wdata_o,
    output logic [data_width_p/8-1:0] wstrb_o,
    output logic                      wvalid_o,
    input  logic                      wready_i,
    // B channel
    input  logic [1:0]                bresp_i,
    input  logic                      bvalid_i,
    output logic                      bready_o,
    // AR channel
    output logic [addr_width_p-1:0]   araddr_o,
    output logic [2:0]                arprot_o,
    output logic                      arvalid_o,
    input  logic                      arready_i,
    // R channel
    input  logic [data_width_p-1:0]   rdata_i,
    input  logic [1:0]                rresp_i,
    input  logic                      rvalid_i,
    output logic                      rready_o
);

    localparam int unsigned cnt_width_lp = $clog2(timeout_cycles_p + 1);

    state_e r_state;
    cmd_t   r_cmd;
    resp_t  r_resp;
    logic   r_cmd_ready, r_resp_v, r_timeout;
    logic   r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic   r_aw_done, r_w_done;

    logic   w_accept, w_aw_fin, w_w_fin, w_cnt_en, w_wdog_hit;

    assign w_accept = cmd_v_i & r_cmd_ready;
    // A channel counts as done once its handshake has happened, now or earlier.
    assign w_aw_fin = r_aw_done | (r_awvalid & awready_i);
    assign w_w_fin  = r_w_done  | (r_wvalid  & wready_i);
    assign w_cnt_en = (r_state == ST_WR_REQ) || (r_state == ST_WR_RESP) ||
                      (r_state == ST_RD_REQ) || (r_state == ST_RD_RESP);

    sat_counter #(
        .width_p    (cnt_width_lp),
        .terminal_p (cnt_width_lp'(timeout_cycles_p))
    ) u_wdog (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_clear   (w_accept),
        .i_en      (w_cnt_en),
        .o_reach   (w_wdog_hit)
    );

    // Transaction FSM; all handshake and payload outputs are registered here.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_resp      <= '0;
            r_cmd_ready <= 1'b0;
            r_resp_v    <= 1'b0;
            r_timeout   <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            // Sticky: once the slave has stalled too long, stay flagged until reset.
            r_timeout <= r_timeout | w_wdog_hit;
            case (r_state)
                ST_IDLE: begin
                    // NOTE: with non-blocking assignments the last write in the
                    // block wins, so the accept branch overrides this default.
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_cmd       <= cmd_t'{we: cmd_we_i, addr: cmd_addr_i,
                                              data: cmd_data_i, strb: cmd_strb_i};
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        if (cmd_we_i) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    r_aw_done <= w_aw_fin;
                    r_w_done  <= w_w_fin;
                    if (w_aw_fin) r_awvalid <= 1'b0;
                    if (w_w_fin)  r_wvalid  <= 1'b0;
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid_i) begin
                        r_bready <= 1'b0;
                        r_resp   <= resp_t'{we: 1'b1, data: '0, code: bresp_i};
                        r_resp_v <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RD_REQ: begin
                    if (arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (rvalid_i) begin
                        r_rready <= 1'b0;
                        r_resp   <= resp_t'{we: 1'b0, data: rdata_i, code: rresp_i};
                        r_resp_v <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        r_resp_v    <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign resp_v_o    = r_resp_v;
    assign resp_we_o   = r_resp.we;
    assign resp_data_o = r_resp.data;
    assign resp_code_o = r_resp.code;
    assign timeout_o   = r_timeout;

    assign awaddr_o  = r_cmd.addr;
    assign awprot_o  = 3'b000;
    assign awvalid_o = r_awvalid;
    assign wdata_o   = r_cmd.data;
    assign wstrb_o   = r_cmd.strb;
    assign wvalid_o  = r_wvalid;
    assign bready_o  = r_bready;
    assign araddr_o  = r_cmd.addr;
    assign arprot_o  = 3'b000;
    assign arvalid_o = r_arvalid;
    assign rready_o  = r_rready;

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Directed bench for axi4_lite_cmd_master with a 16-cycle watchdog.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_axi4_lite_cmd_master;
    import axi4_lite_pkg::*;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        cmd_v_i, cmd_ready_o, cmd_we_i;
    logic [27:0] cmd_addr_i;
    logic [63:0] cmd_data_i;
    logic [7:0]  cmd_strb_i;
    logic        resp_v_o, resp_ready_i, resp_we_o;
    logic [63:0] resp_data_o;
    logic [1:0]  resp_code_o;
    logic        timeout_o;
    logic [27:0] awaddr_o, araddr_o;
    logic [2:0]  awprot_o, arprot_o;
    logic        awvalid_o, awready_i, wvalid_o, wready_i;
    logic [63:0] wdata_o, rdata_i;
    logic [7:0]  wstrb_o;
    logic [1:0]  bresp_i, rresp_i;
    logic        bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    axi4_lite_cmd_master #(.timeout_cycles_p(TO)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_strb_i(cmd_strb_i),
        .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_we_o(resp_we_o),
        .resp_data_o(resp_data_o), .resp_code_o(resp_code_o), .timeout_o(timeout_o),
        .awaddr_o(awaddr_o), .awprot_o(awprot_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .araddr_o(araddr_o), .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a command for one accepting edge; caller is in a cycle with cmd_ready_o=1.
    task automatic issue(input logic we, input logic [27:0] addr, input logic [63:0] data,
                         input logic [7:0] strb);
        cmd_v_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_data_i = data; cmd_strb_i = strb;
        tick();
        cmd_v_i = 1'b0;
    endtask

    // Write whose AW / W readies are high only in cycle aw_cyc / w_cyc after accept.
    task automatic write_skewed(input string tag, input int aw_cyc, input int w_cyc,
                                input logic [27:0] addr, input logic [63:0] data,
                                input logic [1:0] bresp);
        int last;
        last = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
        issue(1'b1, addr, data, 8'hFF);
        for (int c = 1; c <= last; c++) begin
            check({tag, ".awvalid"}, 64'(awvalid_o), 64'(c <= aw_cyc));
            check({tag, ".wvalid"},  64'(wvalid_o),  64'(c <= w_cyc));
            check({tag, ".bready"},  64'(bready_o),  64'(0));
            if (c == 1) begin
                check({tag, ".awaddr"}, 64'(awaddr_o), 64'(addr));
                check({tag, ".wdata"},  wdata_o, data);
                check({tag, ".wstrb"},  64'(wstrb_o), 64'hFF);
                check({tag, ".cmd_ready"}, 64'(cmd_ready_o), 64'(0));
            end
            awready_i = (c == aw_cyc);
            wready_i  = (c == w_cyc);
            tick();
        end
        awready_i = 1'b0; wready_i = 1'b0;
        check({tag, ".bready_on"}, 64'(bready_o), 64'(1));
        check({tag, ".aw_w_low"},  64'({awvalid_o, wvalid_o}), 64'(0));
        check({tag, ".resp_v_early"}, 64'(resp_v_o), 64'(0));
        bvalid_i = 1'b1; bresp_i = bresp;
        tick();
        check({tag, ".resp_v"},    64'(resp_v_o), 64'(1));
        check({tag, ".resp_code"}, 64'(resp_code_o), 64'(bresp));
        check({tag, ".resp_data"}, resp_data_o, 64'(0));
        check({tag, ".resp_we"},   64'(resp_we_o), 64'(1));
        check({tag, ".bready_off"}, 64'(bready_o), 64'(0));
        bvalid_i = 1'b0; resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check({tag, ".idle_ready"}, 64'(cmd_ready_o), 64'(1));
        check({tag, ".resp_v_drop"}, 64'(resp_v_o), 64'(0));
    endtask

    // Zero-wait read with R data offered early (held off until rready).
    task automatic do_read(input string tag, input logic [27:0] addr, input logic [63:0] rdata,
                           input logic [1:0] rresp);
        arready_i = 1'b1;
        issue(1'b0, addr, 64'(0), 8'h00);
        check({tag, ".arvalid"}, 64'(arvalid_o), 64'(1));
        check({tag, ".araddr"},  64'(araddr_o), 64'(addr));
        check({tag, ".rready_early"}, 64'(rready_o), 64'(0));
        rvalid_i = 1'b1; rdata_i = rdata; rresp_i = rresp;
        tick();
        arready_i = 1'b0;
        check({tag, ".arvalid_off"}, 64'(arvalid_o), 64'(0));
        check({tag, ".rready"}, 64'(rready_o), 64'(1));
        tick();
        check({tag, ".resp_v"},    64'(resp_v_o), 64'(1));
        check({tag, ".resp_data"}, resp_data_o, rdata);
        check({tag, ".resp_code"}, 64'(resp_code_o), 64'(rresp));
        check({tag, ".resp_we"},   64'(resp_we_o), 64'(0));
        rvalid_i = 1'b0; rdata_i = '0; resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check({tag, ".idle_ready"}, 64'(cmd_ready_o), 64'(1));
    endtask

    initial begin
        reset_n_i = 1'b0;
        cmd_v_i = 0; cmd_we_i = 0; cmd_addr_i = '0; cmd_data_i = '0; cmd_strb_i = '0;
        resp_ready_i = 0; awready_i = 0; wready_i = 0; bresp_i = 0; bvalid_i = 0;
        arready_i = 0; rdata_i = '0; rresp_i = 0; rvalid_i = 0;
        repeat (3) tick();

        // Reset state
        check("rst.valids", 64'({awvalid_o, wvalid_o, arvalid_o, resp_v_o}), 64'(0));
        check("rst.readies", 64'({cmd_ready_o, bready_o, rready_o}), 64'(0));
        check("rst.resp", 64'({resp_we_o, resp_code_o}), 64'(0));
        check("rst.resp_data", resp_data_o, 64'(0));
        check("rst.timeout", 64'(timeout_o), 64'(0));
        check("rst.prot", 64'({awprot_o, arprot_o}), 64'(0));
        reset_n_i = 1'b1;
        tick();
        check("rst.cmd_ready", 64'(cmd_ready_o), 64'(1));

        // Zero-wait write, then read back, then a read with SLVERR
        write_skewed("wr0", 1, 1, 28'h0000100, 64'h0123456789ABCDEF, OKAY);
        do_read("rd0", 28'h0000100, 64'h0123456789ABCDEF, OKAY);
        do_read("rd_slverr", 28'h0000108, 64'hDEAD_BEEF_0000_0001, SLVERR);

        // AW/W skew both ways; DECERR and EXOKAY pass straight through
        write_skewed("skew_w_first", 6, 1, 28'h0000200, 64'hA5A5_5A5A_0F0F_F0F0, DECERR);
        write_skewed("skew_aw_first", 1, 3, 28'h0000208, 64'h1111_2222_3333_4444, EXOKAY);

        // Response back-pressure: payload held, pending command not taken early
        arready_i = 1'b1;
        issue(1'b0, 28'h0000300, 64'(0), 8'h00);
        rvalid_i = 1'b1; rdata_i = 64'hCAFE_F00D_1234_5678; rresp_i = OKAY;
        tick();
        arready_i = 1'b0;
        tick();
        rvalid_i = 1'b0; rdata_i = '0;
        cmd_v_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 28'h0000310;
        cmd_data_i = 64'h0BAD_CAFE_0000_0042; cmd_strb_i = 8'h0F;
        for (int i = 0; i < 10; i++) begin
            check("bp.resp_v", 64'(resp_v_o), 64'(1));
            check("bp.resp_data", resp_data_o, 64'hCAFE_F00D_1234_5678);
            check("bp.cmd_ready", 64'(cmd_ready_o), 64'(0));
            check("bp.no_aw", 64'(awvalid_o), 64'(0));
            tick();
        end
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check("bp.resp_v_drop", 64'(resp_v_o), 64'(0));
        check("bp.next_ready", 64'(cmd_ready_o), 64'(1));
        awready_i = 1'b1; wready_i = 1'b1;
        tick();
        cmd_v_i = 1'b0;
        check("bp.next_aw", 64'(awvalid_o), 64'(1));
        check("bp.next_awaddr", 64'(awaddr_o), 64'h0000310);
        check("bp.next_wstrb", 64'(wstrb_o), 64'h0F);
        tick();
        awready_i = 1'b0; wready_i = 1'b0;
        check("bp.next_bready", 64'(bready_o), 64'(1));
        bvalid_i = 1'b1; bresp_i = OKAY;
        tick();
        bvalid_i = 1'b0;
        check("bp.next_resp_v", 64'(resp_v_o), 64'(1));
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;

        // Watchdog: AR stalled 20 cycles; flag rises after the 16th stall cycle
        issue(1'b0, 28'h0000400, 64'(0), 8'h00);
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("wd.arvalid_c%0d", c), 64'(arvalid_o), 64'(1));
            check($sformatf("wd.timeout_c%0d", c), 64'(timeout_o), 64'(c >= TO + 1));
            if (c == 20) arready_i = 1'b1;
            tick();
        end
        arready_i = 1'b0;
        check("wd.rready", 64'(rready_o), 64'(1));
        rvalid_i = 1'b1; rdata_i = 64'h0000_0000_0000_4040; rresp_i = OKAY;
        tick();
        rvalid_i = 1'b0;
        check("wd.resp_v", 64'(resp_v_o), 64'(1));
        check("wd.resp_data", resp_data_o, 64'h4040);
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check("wd.sticky_idle", 64'(timeout_o), 64'(1));
        do_read("wd_after", 28'h0000408, 64'h77, OKAY);
        check("wd.sticky_after", 64'(timeout_o), 64'(1));

        // Reset while waiting in WR_RESP
        awready_i = 1'b1; wready_i = 1'b1;
        issue(1'b1, 28'h0000500, 64'h5555, 8'hFF);
        tick();
        awready_i = 1'b0; wready_i = 1'b0;
        check("mr.bready_before", 64'(bready_o), 64'(1));
        reset_n_i = 1'b0;
        tick();
        check("mr.valids", 64'({awvalid_o, wvalid_o, arvalid_o, resp_v_o}), 64'(0));
        check("mr.readies", 64'({cmd_ready_o, bready_o, rready_o}), 64'(0));
        check("mr.timeout", 64'(timeout_o), 64'(0));
        reset_n_i = 1'b1;
        tick();
        check("mr.idle_ready", 64'(cmd_ready_o), 64'(1));
        do_read("mr_after", 28'h0000100, 64'h0123456789ABCDEF, OKAY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
